wb_master_lsu: RTL
==================

Name: wb_master_lsu

Overview:
- Wishbone pipelined bus initiator for the core's load/store path; drives the `block_ram` responder (`i_wb_stb`/`i_wb_we`/`i_wb_sel`/`i_addr`/`i_data` in, `o_wb_data`/`o_wb_stall`/`o_wb_ack` out).
- Accepts one core memory request at a time and checks alignment.
- Issues a single Wishbone cycle and handles stall/ack.
- Returns sign/zero-extended load data or a write completion to the core as a one-cycle response.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYCLES, 64, cycles `o_wb_cyc` may stay high without ack before abort. Used only with WB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  1  core request valid.
- o_req_ready  out  1  block can accept a request (high only in IDLE).
- i_req_we  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are loads only.
- i_req_addr  in  XLEN  byte address.
- i_req_wdata  in  XLEN  store data, low bits significant.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_data  out  XLEN  extended load data. Zero for stores and errors.
- o_rsp_err  out  1  qualified by o_rsp_valid: misaligned, illegal funct3, or timeout.
- o_wb_cyc  out  1  bus cycle active.
- o_wb_stb  out  1  strobe.
- o_wb_we  out  1  write enable.
- o_wb_addr  out  XLEN  address to responder.
- o_wb_data  out  XLEN  write data to responder.
- o_wb_sel  out  3  funct3 passed to responder.
- i_wb_data  in  XLEN  read data from responder.
- i_wb_stall  in  1  responder not accepting strobe.
- i_wb_ack  in  1  responder completion.

Behaviour:
- Clocking: one clock (i_clk). Reset (i_reset) is synchronous and active-high.
- Reset values: state IDLE. o_req_ready=1 after the first reset cycle. All other outputs 0. o_wb_addr, o_wb_data, o_wb_sel = 0.
- States: IDLE, STROBE, WAIT_ACK, RESP.
- IDLE: on i_req_valid & o_req_ready, latch we/funct3/addr/wdata.
  - Request is illegal if funct3 ∉ {000,001,010,100,101}, or we=1 with funct3[2]=1.
  - Request is misaligned if funct3[1:0]=01 and addr[0]=1, or funct3[1:0]=10 and addr[1:0]≠0.
  - Illegal or misaligned: go to RESP with err=1. No bus activity.
  - Otherwise: go to STROBE, with cyc=stb=1 on the next cycle.
- STROBE: cyc=1, stb=1, bus outputs stable.
  - If i_wb_stall=1: stay. Stb and all bus fields held unchanged.
  - If i_wb_stall=0: strobe accepted. stb=0 next cycle. If i_wb_ack is also 1 in this cycle, go to RESP; else go to WAIT_ACK.
- WAIT_ACK: cyc=1, stb=0. On i_wb_ack=1, capture i_wb_data, drop cyc next cycle, go to RESP.
- i_wb_ack in IDLE or RESP is ignored. i_wb_ack while stalled in STROBE is ignored.
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. o_req_ready=0 in this cycle.
- Load extension, from captured data bits:
  - 000: sext[7:0].
  - 100: zext[7:0].
  - 001: sext[15:0].
  - 101: zext[15:0].
  - 010: full word.
- Stores: o_rsp_data=0.
- Latency, zero-stall responder acking one cycle after strobe:
  - Accept edge at cycle 0.
  - stb in cycle 1.
  - ack in cycle 2.
  - o_rsp_valid in cycle 3.
- Error latency: o_rsp_valid in cycle 1 after accept.
- Each stall cycle adds exactly one cycle.
- Back-to-back: next request accepted the cycle after RESP. No overlapping transactions, max one outstanding.
- Reset mid-operation: next edge returns to IDLE, cyc/stb=0, no response pulse. The in-flight transaction is abandoned.
- o_wb_we and o_wb_sel stay constant from STROBE through WAIT_ACK.

Optional Feature:
- WB_TIMEOUT_EN defined:
  - Counter cleared on entry to STROBE, increments each cycle cyc=1 without ack.
  - On reaching TIMEOUT_CYCLES: drop cyc/stb next edge, go to RESP with err=1, data=0.
  - Ack arriving in the same cycle as the limit wins (normal response).
- Not defined: no counter. The block waits indefinitely in STROBE/WAIT_ACK.

Test Plan:
- Word load, addr 0x10, responder returns 0xDEADBEEF, no stall, ack next cycle → o_rsp_valid in cycle 3, data 0xDEADBEEF, err=0; o_wb_sel=010, o_wb_we=0.
- LB and LBU at addr 0x4, responder returns 0x00000080 → rsp data 0xFFFFFF80 and 0x00000080 respectively.
- SW addr 0x8, data 0x12345678, i_wb_stall high 3 cycles → stb held 3 extra cycles with constant addr/data; rsp in cycle 6, err=0, data=0.
- LW addr 0x6 / SH addr 0x3 / funct3=110 → err=1 response one cycle after accept; cyc never asserted.
- Reset asserted during WAIT_ACK → outputs zero next cycle, no rsp pulse; late ack ignored; next request completes normally.
- With WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, responder never acks → cyc drops after 8 cycles, rsp err=1. Without the macro, cyc stays high through 100 cycles.

Source files
------------

// File: rtl/wb_master_lsu.sv
// wb_master_lsu: Wishbone pipelined initiator for the core load/store path.
//
// Takes one core memory request at a time, checks funct3 legality and
// alignment, runs a single Wishbone cycle (handling stall and ack), then
// returns a one-cycle response carrying sign/zero-extended load data or a
// store completion.
//
// Optional feature macro: WB_TIMEOUT_EN. When defined, a bus cycle that
// stays open for TIMEOUT_CYCLES cycles without an ack is aborted and
// answered with an error. When undefined, the block waits indefinitely.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_req_valid/o_req_ready core request handshake (ready only in IDLE)
//   i_req_we, i_req_funct3  store flag, RISC-V size code
//   i_req_addr, i_req_wdata byte address, store data
//   o_rsp_valid/data/err    one-cycle response pulse
//   o_wb_cyc/stb/we/addr/data/sel, i_wb_data/stall/ack  Wishbone bus
module wb_master_lsu #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_rsp_valid,
    output logic [XLEN-1:0] o_rsp_data,
    output logic            o_rsp_err,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [XLEN-1:0] o_wb_addr,
    output logic [XLEN-1:0] o_wb_data,
    output logic [2:0]      o_wb_sel,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT_ACK, RESP} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t          state, state_nx;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic            err_q;

    logic            accept;
    logic            illegal, misaligned, bad;
    logic            ack_take;
    logic            timeout;

    assign accept = i_req_valid && (state == IDLE);

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (i_req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = i_req_we;  // unsigned sizes are load-only
            default:                illegal = 1'b1;
        endcase
        case (i_req_funct3[1:0])
            2'b01:   misaligned = i_req_addr[0];
            2'b10:   misaligned = (i_req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        bad = illegal || misaligned;
    end

    // An ack counts only once the strobe is accepted (not while stalled).
    assign ack_take = i_wb_ack &&
                      ((state == STROBE && !i_wb_stall) || state == WAIT_ACK);

`ifdef WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    // Fires on the TIMEOUT_CYCLES-th open cycle; an ack in that cycle wins.
    assign timeout = (state == STROBE || state == WAIT_ACK) && !ack_take &&
                     (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset)
            tmo_cnt <= '0;
        else if (accept)
            tmo_cnt <= '0;
        else if ((state == STROBE || state == WAIT_ACK) && !ack_take && !timeout)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = bad ? RESP : STROBE;
            STROBE: begin
                if (ack_take || timeout) state_nx = RESP;
                else if (!i_wb_stall)    state_nx = WAIT_ACK;
            end
            WAIT_ACK: if (ack_take || timeout) state_nx = RESP;
            RESP:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= i_req_we;
                f3_q    <= i_req_funct3;
                addr_q  <= i_req_addr;
                wdata_q <= i_req_wdata;
                rdata_q <= '0;
                err_q   <= bad;
            end else if (ack_take) begin
                rdata_q <= i_wb_data;
            end else if (timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign o_req_ready = (state == IDLE);
    assign o_rsp_valid = (state == RESP);
    assign o_rsp_err   = (state == RESP) && err_q;
    assign o_wb_cyc    = (state == STROBE) || (state == WAIT_ACK);
    assign o_wb_stb    = (state == STROBE);
    assign o_wb_we     = o_wb_cyc && we_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = wdata_q;
    assign o_wb_sel    = f3_q;

    always_comb begin
        o_rsp_data = '0;
        if (state == RESP && !err_q && !we_q) begin
            case (f3_q)
                3'b000:  o_rsp_data = {{(XLEN-8){rdata_q[7]}}, rdata_q[7:0]};
                3'b100:  o_rsp_data = {{(XLEN-8){1'b0}}, rdata_q[7:0]};
                3'b001:  o_rsp_data = {{(XLEN-16){rdata_q[15]}}, rdata_q[15:0]};
                3'b101:  o_rsp_data = {{(XLEN-16){1'b0}}, rdata_q[15:0]};
                3'b010:  o_rsp_data = rdata_q;
                default: o_rsp_data = '0;
            endcase
        end
    end

endmodule
